// File: rtl/countdown_pkg.sv
// Shared definitions for countdown_indexer: state encoding and the
// load-value clamp helper.
`ifndef COUNTDOWN_PKG_SV
`define COUNTDOWN_PKG_SV

package countdown_pkg;

    // State encoding
    localparam logic ST_ACTIVE = 1'b0;
    localparam logic ST_HALT   = 1'b1;

    // Clamp a start index into 0..size-1 (saturate, never wrap)
    function automatic int unsigned clamp_idx(input int unsigned val,
                                              input int unsigned size);
        return (val > size - 1) ? size - 1 : val;
    endfunction

endpackage

`endif

// File: rtl/countdown_indexer.sv
// countdown_indexer: loadable down-counting index over 0..SIZE-1 with a
// valid/ready step interface. It either wraps 0 -> SIZE-1 (WRAP=1) or
// halts at 0 (WRAP=0) until the next load.
//
// Parameters:
//   SIZE        index range 0..SIZE-1 (SIZE >= 2)
//   WRAP        1: wrap at 0, 0: halt at 0
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset (wins over load/step)
//   load        load a new start index (wins over step)
//   load_val    start index, clamped to SIZE-1
//   step_valid  decrement request
//   step_ready  step accepted this cycle (ACTIVE and no load)
//   idx         current index (registered)
//   first       idx == 0
//   wrap        one-cycle pulse after a wrapping step
//   halted      state is HALT
//   underflow_cnt  (only with COUNTDOWN_INDEXER_UNDERFLOW_EN) saturating
//                  count of step_valid cycles spent in HALT
`ifndef COUNTDOWN_INDEXER_SV
`define COUNTDOWN_INDEXER_SV

module countdown_indexer
    import countdown_pkg::*;
#(
    parameter int unsigned SIZE = 8,
    parameter bit          WRAP = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [$clog2(SIZE)-1:0] load_val,
    input  logic                    step_valid,
    output logic                    step_ready,
    output logic [$clog2(SIZE)-1:0] idx,
    output logic                    first,
    output logic                    wrap,
    output logic                    halted
`ifdef COUNTDOWN_INDEXER_UNDERFLOW_EN
    ,
    output logic [7:0]              underflow_cnt
`endif
);

    localparam int unsigned W = $clog2(SIZE);
    localparam logic [W-1:0] IDX_MAX = W'(SIZE - 1);

    logic         state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic         wrap_q, wrap_d;
    logic         step_acc;

    assign step_acc = step_valid && step_ready;

    // State, index and wrap-pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACTIVE;
            idx_q   <= IDX_MAX;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next-state logic; load beats step because step_ready drops on load
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        if (load) begin
            idx_d   = W'(clamp_idx(32'(load_val), SIZE));
            state_d = ST_ACTIVE;
        end else if (step_acc) begin
            if (idx_q != '0) begin
                idx_d = idx_q - W'(1);
            end else if (WRAP) begin
                idx_d  = IDX_MAX;
                wrap_d = 1'b1;
            end else begin
                state_d = ST_HALT;
            end
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        step_ready = (state_q == ST_ACTIVE) && !load;
        first      = (idx_q == '0);
        halted     = (state_q == ST_HALT);
    end

    assign idx  = idx_q;
    assign wrap = wrap_q;

`ifdef COUNTDOWN_INDEXER_UNDERFLOW_EN
    // Steps requested while halted, saturating at 255
    always_ff @(posedge clk) begin
        if (rst || load) begin
            underflow_cnt <= 8'd0;
        end else if ((state_q == ST_HALT) && step_valid && (underflow_cnt != 8'hFF)) begin
            underflow_cnt <= underflow_cnt + 8'd1;
        end
    end
`endif

endmodule

`endif
